// File: rtl/regfile16_pkg.sv
// Shared constants for the 16-entry register file with pending-destination
// (busy) tracking.
package regfile16_pkg;

  localparam int BIT_WIDTH = 8;
  localparam int REG_COUNT = 16;
  localparam int REG_SEL_W = 4;

endpackage

// File: rtl/regfile16_mux16.sv
// 16:1 selector of W-bit words. The register file uses it for read data and
// for per-port busy lookup.
module regfile16_mux16
  import regfile16_pkg::*;
#(
  parameter int W = BIT_WIDTH
) (
  input  logic [REG_COUNT-1:0][W-1:0] din,
  input  logic [REG_SEL_W-1:0]        sel,
  output logic [W-1:0]                dout
);

  assign dout = din[sel];

endmodule

// File: rtl/regfile16.sv
// Register file: 16 registers, two combinational read ports with write-back
// bypass, one write-back port and a reservation port that marks registers pending.
module regfile16
  import regfile16_pkg::*;
#(
  parameter int n = BIT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REG_SEL_W-1:0] rd_sel_a,
  output logic [n-1:0]         rd_data_a,
  output logic                 rd_valid_a,
  input  logic [REG_SEL_W-1:0] rd_sel_b,
  output logic [n-1:0]         rd_data_b,
  output logic                 rd_valid_b,
  input  logic                 wr_en,
  input  logic [REG_SEL_W-1:0] wr_sel,
  input  logic [n-1:0]         wr_data,
  input  logic                 rsv_en,
  input  logic [REG_SEL_W-1:0] rsv_sel,
  output logic                 rsv_ready,
  output logic [REG_COUNT-1:0] busy
);

  // Reservation handshake: rsv_en is the request, rsv_ready the acceptance.
  // A reservation takes effect only on a rising edge where both are high;
  // rsv_ready never depends on rsv_en.

  logic [REG_COUNT-1:0][n-1:0] regs_q, regs_d;
  logic [REG_COUNT-1:0]        busy_q, busy_d;
  logic [REG_COUNT-1:0][0:0]   busy_arr;
  logic [n-1:0]                mux_data_a, mux_data_b;
  logic [0:0]                  mux_busy_a, mux_busy_b;
  logic                        wr_hit_a, wr_hit_b;

  assign busy_arr = busy_q;
  assign busy     = busy_q;

  assign rsv_ready = !busy_q[rsv_sel] || (wr_en && (wr_sel == rsv_sel));

  // Write clears busy first so a same-index reservation wins.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_en) begin
      regs_d[wr_sel] = wr_data;
      busy_d[wr_sel] = 1'b0;
    end
    if (rsv_en && rsv_ready) begin
      busy_d[rsv_sel] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  regfile16_mux16 #(.W(n)) u_mux_data_a (.din(regs_q),   .sel(rd_sel_a), .dout(mux_data_a));
  regfile16_mux16 #(.W(n)) u_mux_data_b (.din(regs_q),   .sel(rd_sel_b), .dout(mux_data_b));
  regfile16_mux16 #(.W(1)) u_mux_busy_a (.din(busy_arr), .sel(rd_sel_a), .dout(mux_busy_a));
  regfile16_mux16 #(.W(1)) u_mux_busy_b (.din(busy_arr), .sel(rd_sel_b), .dout(mux_busy_b));

  // Bypass sits after the muxes: in-flight write data is always final.
  assign wr_hit_a = wr_en && (wr_sel == rd_sel_a);
  assign wr_hit_b = wr_en && (wr_sel == rd_sel_b);

  assign rd_data_a  = wr_hit_a ? wr_data : mux_data_a;
  assign rd_valid_a = wr_hit_a | ~mux_busy_a[0];
  assign rd_data_b  = wr_hit_b ? wr_data : mux_data_b;
  assign rd_valid_b = wr_hit_b | ~mux_busy_b[0];

endmodule
